pwm_fade_sequencer: RTL and testbench
=====================================

# pwm_fade_sequencer

Sequencer that drives the duty-cycle and period inputs of the team's `PWM_core` LED dimmer, so the LED fades ("breathes") without CPU involvement. A host writes a low level, high level, step dwell and period through a small register port. On `start` the block ramps the duty value from low up to high and back down, one step per dwell interval, either once or continuously. It sits between the Qsys slave decode and the PWM core: `duty_out` feeds the core's `switch_in`, `period_out` feeds `pulse_period`, and `duty_load` qualifies the core's `byteenable[0]`.

## Interface
- `N`, 8: duty width; must match the PWM core `n`.
- `STEP`, 1: duty increment/decrement per step, 1..2^N-1.
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `wr_en` in 1: register write strobe, one cycle per write.
- `wr_addr` in 2: register select. 0 = period/mode, 1 = low level, 2 = high level, 3 = dwell.
- `wr_data` in 16: write data.
- `start` in 1: begin fade sequence (level, sampled each cycle).
- `stop` in 1: abort sequence.
- `duty_out` out N: current duty value to the PWM core.
- `period_out` out N+1: PWM period to the PWM core.
- `duty_load` out 1: one-cycle pulse whenever `duty_out` changes.
- `busy` out 1: sequence active.
- `done` out 1: one-cycle pulse when a non-looping sequence completes.

## Operation
- Registers and reset values:
  - PERIOD = `wr_data[N:0]`, reset 2^N-1.
  - LOOP = `wr_data[15]` at addr 0, reset 0.
  - LOW = `wr_data[N-1:0]`, reset 0.
  - HIGH = `wr_data[N-1:0]`, reset 2^N-1.
  - DWELL = `wr_data[15:0]`, reset 0.
- Write rules:
  - Writes to addr 0 take effect at any time.
  - Writes to addrs 1–3 while `busy` is high are dropped.
  - `period_out` always equals PERIOD.
- Output reset values: `duty_out` 0, `period_out` 2^N-1, `duty_load` 0, `busy` 0, `done` 0, state IDLE, dwell counter 0.
- States: IDLE, UP, DOWN. `busy` = (state != IDLE).
- **IDLE**
  - `start` & !`stop` & LOW<=HIGH → UP, `duty_out`<=LOW, `duty_load` pulse, counter<=DWELL.
  - `start` with LOW>HIGH is ignored.
- **Dwell counter** (UP/DOWN)
  - Each cycle: counter==0 → expiry, counter<=DWELL.
  - Otherwise counter decrements.
  - Step interval is DWELL+1 cycles; DWELL=0 steps every cycle.
- **UP expiry**
  - `duty_out`==HIGH → DOWN, duty unchanged, no `duty_load`.
  - Otherwise `duty_out`<=min(`duty_out`+STEP, HIGH), `duty_load` pulse.
- **DOWN expiry**
  - `duty_out`==LOW:
    - LOOP=1 → UP, duty unchanged.
    - LOOP=0 → IDLE with `done` pulse.
  - Otherwise `duty_out`<=max(`duty_out`-STEP, LOW), `duty_load` pulse.
- Arithmetic:
  - Compute the sum/difference in N+1 bits, then saturate. No wrap past 2^N-1 or below 0.
  - Endpoints are exact even when (HIGH-LOW) is not a multiple of STEP.
- `stop` (any state) → IDLE next cycle.
  - `duty_out` holds its current value.
  - No `done` pulse, no `duty_load`.
  - `stop` beats `start` in the same cycle.
- `start` while `busy` is ignored.
- LOW==HIGH: UP expires straight into DOWN, then DOWN finishes. No duty change after the initial load.
- `reset` mid-sequence returns all outputs and registers to their reset values on the next edge.

## Timing
- All outputs are registered.
- `start` sampled at edge t → `busy`=1, `duty_out`=LOW, `duty_load`=1 after edge t.
- In UP/DOWN, expiry happens on the cycle the counter is 0. Resulting `duty_out`/state/`done` are visible after that edge.
- First step is visible DWELL+1 cycles after the initial load.
- `duty_load` and `done` are exactly one cycle wide. `done` coincides with `busy` falling.
- Register write at edge t is visible in `period_out`/registers after edge t; a `start` at edge t+1 uses the new values.

## Test plan
- Reset → `duty_out`=0, `period_out`=255, `busy`=0, `done`=0, `duty_load`=0 (N=8).
- LOW=10, HIGH=13, DWELL=2, LOOP=0, start at t:
  - `duty_out` =10@t+1, 11@t+4, 12@t+7, 13@t+10.
  - Turnaround at t+13 with no `duty_load`.
  - `duty_out` =12@t+16, 11@t+19, 10@t+22.
  - `done` pulse and `busy`=0 @t+25.
- STEP=4, LOW=0, HIGH=10, DWELL=0 → `duty_out` 0,4,8,10,(hold),6,2,0 → `done`; no value above 10 or below 0.
- LOOP=1, LOW=5, HIGH=6, DWELL=0 → 5,6,6,5,5,6,… continuously with `busy`=1. Assert `stop` → IDLE next cycle, `duty_out` frozen, no `done`.
- Edge cases:
  - Write HIGH while busy → ignored; sequence ends at the old HIGH.
  - Write PERIOD=100 while busy → `period_out`=100 next cycle.
  - `start`+`stop` together in IDLE → stays IDLE.
  - LOW=20, HIGH=10 start → ignored.
- Synchronous `reset` asserted mid-UP → next cycle all outputs at their reset values; a subsequent `start` runs normally.

Source files
------------

// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer
//
// Ramps the PWM core duty value from a low level up to a high level and back down, one step per
// dwell interval, once or continuously, so an LED "breathes" without CPU involvement.
//
// Parameters:
//   N     - duty width (must match the PWM core)
//   STEP  - duty increment/decrement per step, 1..2^N-1
// Ports:
//   clk_i         - system clock, rising edge
//   reset_i       - synchronous active-high reset
//   wr_en_i       - register write strobe
//   wr_addr_i     - 0 period/loop, 1 low level, 2 high level, 3 dwell
//   wr_data_i     - register write data
//   start_i       - begin fade sequence (level)
//   stop_i        - abort sequence
//   duty_out_o    - current duty value (PWM core switch_in)
//   period_out_o  - PWM period (PWM core pulse_period)
//   duty_load_o   - one-cycle pulse whenever duty_out_o changes
//   busy_o        - sequence active
//   done_o        - one-cycle pulse when a non-looping sequence completes

module pwm_fade_sequencer #(
  parameter int unsigned N    = 8,
  parameter int unsigned STEP = 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         wr_en_i,
  input  logic [1:0]   wr_addr_i,
  input  logic [15:0]  wr_data_i,
  input  logic         start_i,
  input  logic         stop_i,
  output logic [N-1:0] duty_out_o,
  output logic [N:0]   period_out_o,
  output logic         duty_load_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StUp   = 2'd1;
  localparam logic [1:0] StDown = 2'd2;

  localparam logic [N:0]   StepExt = (N+1)'(STEP);
  localparam logic [N-1:0] MaxLvl  = {N{1'b1}};

  logic [1:0]   state_q, state_d;
  logic [N:0]   period_q, period_d;
  logic         loop_q, loop_d;
  logic [N-1:0] low_q, low_d;
  logic [N-1:0] high_q, high_d;
  logic [15:0]  dwell_q, dwell_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [N-1:0] duty_q, duty_d;
  logic         load_q, load_d;
  logic         done_q, done_d;

  // One extra bit so overflow past MaxLvl and underflow below zero are visible before saturating.
  logic [N:0] sum, diff;

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    loop_d   = loop_q;
    low_d    = low_q;
    high_d   = high_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    duty_d   = duty_q;
    load_d   = 1'b0;
    done_d   = 1'b0;

    sum  = {1'b0, duty_q} + StepExt;
    diff = {1'b0, duty_q} - StepExt;

    // Period/mode is always writable; level and dwell registers are frozen while running.
    if (wr_en_i) begin
      if (wr_addr_i == 2'd0) begin
        period_d = wr_data_i[N:0];
        loop_d   = wr_data_i[15];
      end else if (state_q == StIdle) begin
        case (wr_addr_i)
          2'd1:    low_d   = wr_data_i[N-1:0];
          2'd2:    high_d  = wr_data_i[N-1:0];
          default: dwell_d = wr_data_i;
        endcase
      end
    end

    if (stop_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i && (low_q <= high_q)) begin
            state_d = StUp;
            duty_d  = low_q;
            load_d  = 1'b1;
            cnt_d   = dwell_q;
          end
        end
        StUp, StDown: begin
          if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
          end else begin
            cnt_d = dwell_q;
            if (state_q == StUp) begin
              if (duty_q == high_q) begin
                state_d = StDown;
              end else begin
                duty_d = (sum > {1'b0, high_q}) ? high_q : sum[N-1:0];
                load_d = 1'b1;
              end
            end else begin
              if (duty_q == low_q) begin
                if (loop_q) begin
                  state_d = StUp;
                end else begin
                  state_d = StIdle;
                  done_d  = 1'b1;
                end
              end else begin
                // diff[N] set means duty_q < STEP, i.e. the subtraction went below zero.
                duty_d = (diff[N] || (diff[N-1:0] < low_q)) ? low_q : diff[N-1:0];
                load_d = 1'b1;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      period_q <= {1'b0, MaxLvl};
      loop_q   <= 1'b0;
      low_q    <= '0;
      high_q   <= MaxLvl;
      dwell_q  <= '0;
      cnt_q    <= '0;
      duty_q   <= '0;
      load_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      loop_q   <= loop_d;
      low_q    <= low_d;
      high_q   <= high_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      load_q   <= load_d;
      done_q   <= done_d;
    end
  end

  assign duty_out_o   = duty_q;
  assign period_out_o = period_q;
  assign duty_load_o  = load_q;
  assign done_o       = done_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Testbench for pwm_fade_sequencer: a reference model turns each sequence into a timed list of
// duty loads and done pulses; a monitor pops and compares them as the DUT pulses, plus timed
// snapshots of the quiet outputs.

module tb_pwm_fade_sequencer;

  localparam int N    = 8;
  localparam int Step = 3;
  localparam int Big  = 1 << 30;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        stop;
  logic [7:0]  duty_out;
  logic [8:0]  period_out;
  logic        duty_load;
  logic        busy;
  logic        done;

  pwm_fade_sequencer #(
    .N    (N),
    .STEP (Step)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .start_i      (start),
    .stop_i       (stop),
    .duty_out_o   (duty_out),
    .period_out_o (period_out),
    .duty_load_o  (duty_load),
    .busy_o       (busy),
    .done_o       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    bit    is_done;
    int    duty;
    string name;
  } ev_t;

  typedef struct {
    int    cyc;
    bit    full;
    int    duty;
    bit    busy;
    int    period;
    string name;
  } snap_t;

  ev_t   exp_q[$];
  snap_t snap_q[$];

  int checks = 0;
  int errors = 0;
  bit tb_done = 1'b0;

  // Reference model state.
  int m_low    = 0;
  int m_high   = 255;
  int m_dwell  = 0;
  int m_period = 255;
  bit m_loop   = 1'b0;
  int m_duty   = 0;

  task automatic push_ev(input int c, input bit d, input int v, input string nm);
    ev_t e;
    e.cyc = c; e.is_done = d; e.duty = v; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic push_snap(input int c, input bit full, input bit b, input string nm);
    snap_t s;
    s.cyc = c; s.full = full; s.duty = m_duty; s.busy = b; s.period = m_period; s.name = nm;
    snap_q.push_back(s);
  endtask

  // Expected duty loads / done for a sequence whose initial load is at cycle t0; nothing after
  // cycle 'limit' is produced (used for stop/reset aborts and looping).
  task automatic gen(input int t0, input int limit, input string nm);
    int p, k, v, c;
    p = m_dwell + 1;
    v = m_low;
    k = 1;
    if (t0 > limit) return;
    push_ev(t0, 1'b0, v, nm);
    m_duty = v;
    forever begin
      while (v != m_high) begin
        v = (v + Step > m_high) ? m_high : v + Step;
        c = t0 + k * p;
        if (c > limit) return;
        push_ev(c, 1'b0, v, nm);
        m_duty = v;
        k++;
      end
      if (t0 + k * p > limit) return;
      k++;
      while (v != m_low) begin
        v = (v - Step < m_low) ? m_low : v - Step;
        c = t0 + k * p;
        if (c > limit) return;
        push_ev(c, 1'b0, v, nm);
        m_duty = v;
        k++;
      end
      c = t0 + k * p;
      if (c > limit) return;
      if (!m_loop) begin
        push_ev(c, 1'b1, v, nm);
        return;
      end
      k++;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    case (a)
      2'd0: begin
        m_period = int'(d[8:0]);
        m_loop   = d[15];
        push_snap(cyc + 1, 1'b0, 1'b0, "period_write");
      end
      2'd1:    m_low   = int'(d[7:0]);
      2'd2:    m_high  = int'(d[7:0]);
      default: m_dwell = int'(d);
    endcase
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || snap_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic start_seq(input bit ok, input string nm);
    if (ok) gen(cyc + 1, Big, nm);
    else push_snap(cyc + 2, 1'b1, 1'b0, nm);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  task automatic abort_seq(input int len, input bit use_reset, input string nm);
    gen(cyc + 1, cyc + 1 + len, nm);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (len) @(negedge clk);
    if (use_reset) begin
      reset = 1'b1;
      m_low = 0; m_high = 255; m_dwell = 0; m_period = 255; m_loop = 1'b0; m_duty = 0;
    end else begin
      stop = 1'b1;
    end
    push_snap(cyc + 1, 1'b1, 1'b0, nm);
    @(negedge clk);
    reset = 1'b0;
    stop  = 1'b0;
    drain();
  endtask

  // Monitor: compares every DUT pulse and every due snapshot.
  initial begin
    ev_t   e;
    snap_t s;
    bit    ok;
    forever begin
      @(negedge clk);
      if (tb_done) begin
        while (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++; errors++;
          $display("FAIL %s: event never seen, want cyc=%0d done=%0b duty=%0d",
                   e.name, e.cyc, e.is_done, e.duty);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
      if (duty_load === 1'b1 || done === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got cyc=%0d load=%0b done=%0b duty=%0d, want none",
                   cyc, duty_load, done, duty_out);
        end else begin
          e  = exp_q.pop_front();
          ok = (e.cyc == cyc) && (done == e.is_done) && (duty_load == !e.is_done) &&
               (int'(duty_out) == e.duty) && (busy == !e.is_done);
          if (!ok) begin
            errors++;
            $display("FAIL %s: got cyc=%0d load=%0b done=%0b duty=%0d busy=%0b, want cyc=%0d done=%0b duty=%0d",
                     e.name, cyc, duty_load, done, duty_out, busy, e.cyc, e.is_done, e.duty);
          end
        end
      end
      if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL %s: missing pulse at cyc=%0d, want done=%0b duty=%0d",
                 e.name, e.cyc, e.is_done, e.duty);
      end
      while (snap_q.size() != 0 && snap_q[0].cyc <= cyc) begin
        s = snap_q.pop_front();
        checks++;
        if (s.full)
          ok = (s.cyc == cyc) && (int'(duty_out) == s.duty) && (busy == s.busy) &&
               (int'(period_out) == s.period) && (duty_load == 1'b0) && (done == 1'b0);
        else
          ok = (s.cyc == cyc) && (int'(period_out) == s.period);
        if (!ok) begin
          errors++;
          $display("FAIL %s: got cyc=%0d duty=%0d busy=%0b period=%0d load=%0b done=%0b, want cyc=%0d duty=%0d busy=%0b period=%0d",
                   s.name, cyc, duty_out, busy, period_out, duty_load, done,
                   s.cyc, s.duty, s.busy, s.period);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    int lo, hi, dw, tmp;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    push_snap(cyc + 1, 1'b1, 1'b0, "reset_values");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Basic ramp 10..13, dwell 2.
    wr(2'd1, 16'd10); wr(2'd2, 16'd13); wr(2'd3, 16'd2);
    start_seq(1'b1, "ramp_10_13");

    // Saturation at both ends, dwell 0.
    wr(2'd1, 16'd0); wr(2'd2, 16'd10); wr(2'd3, 16'd0);
    start_seq(1'b1, "sat_0_10");

    // LOW == HIGH: single load, then done.
    wr(2'd1, 16'd77); wr(2'd2, 16'd77); wr(2'd3, 16'd1);
    start_seq(1'b1, "low_eq_high");

    // Continuous loop, aborted by stop.
    wr(2'd0, 16'h80FF); wr(2'd1, 16'd5); wr(2'd2, 16'd6); wr(2'd3, 16'd0);
    abort_seq(12, 1'b0, "loop_stop");
    wr(2'd0, 16'h00FF);

    // HIGH write while busy is dropped; PERIOD write while busy lands.
    wr(2'd1, 16'd0); wr(2'd2, 16'd9); wr(2'd3, 16'd1);
    gen(cyc + 1, Big, "busy_writes");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'd200;
    @(negedge clk);
    wr_en = 1'b0;
    wr(2'd0, 16'd100);
    drain();

    // start and stop together in idle.
    start = 1'b1; stop = 1'b1;
    push_snap(cyc + 2, 1'b1, 1'b0, "start_stop_idle");
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    drain();

    // LOW > HIGH is ignored.
    wr(2'd1, 16'd20); wr(2'd2, 16'd10);
    start_seq(1'b0, "low_gt_high");

    // Reset mid-UP, then a default-register sequence runs normally.
    wr(2'd1, 16'd0); wr(2'd2, 16'd50); wr(2'd3, 16'd1);
    abort_seq(5, 1'b1, "reset_mid_up");
    start_seq(1'b1, "after_reset");

    // Randomized sequences.
    for (int i = 0; i < 20; i++) begin
      lo = $urandom_range(0, 255);
      hi = lo + $urandom_range(0, 30);
      if (hi > 255) hi = 255;
      if ($urandom_range(0, 5) == 0 && hi != lo) begin
        tmp = lo; lo = hi; hi = tmp;
      end
      dw = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) wr(2'd0, 16'($urandom_range(0, 511)));
      wr(2'd1, 16'(lo)); wr(2'd2, 16'(hi)); wr(2'd3, 16'(dw));
      start_seq(lo <= hi, "random_seq");
    end

    tb_done = 1'b1;
  end

endmodule
